// File: rtl/mega_mul_seq.sv
// Iterative shift-add sequencer for the AVR MUL/MULS/MULSU/FMUL/FMULS/FMULSU family.
// Sign/magnitude datapath: unsigned 8x8 shift-add over 8 cycles, then one cycle of sign fix-up and result write.
//
// state  | meaning
// IDLE   | waiting for a legal start
// CALC   | one multiplier bit per cycle, LSB first (8 cycles)
// FIX    | apply sign, fractional shift, compute C/Z, write R
// DONE   | one-cycle done strobe; a legal start here chains directly into CALC

module mega_mul_seq #(
    parameter string ZERO_SKIP = "FALSE"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [7:0]  i_rd,
    input  logic [7:0]  i_rr,
    input  logic        i_kill,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_r,
    output logic        o_flag_c,
    output logic        o_flag_z
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam bit SKIP_EN = (ZERO_SKIP == "TRUE");

    state_t      r_state;
    state_t      w_state_nx;
    logic [2:0]  r_cnt;
    logic [7:0]  r_ma;
    logic [7:0]  r_mb;
    logic        r_neg;
    logic        r_frac;
    logic [15:0] r_acc;
    logic [15:0] r_r;
    logic        r_flag_c;
    logic        r_flag_z;

    logic        w_legal;
    logic        w_signed_a;
    logic        w_signed_b;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [7:0]  w_ma;
    logic [7:0]  w_mb;
    logic        w_idle_like;
    logic        w_accept;
    logic        w_zero_op;
    logic [15:0] w_addend;
    logic [15:0] w_acc_nx;
    logic [15:0] w_p;
    logic [15:0] w_r_fix;

    // Operand decode: only signed operands with bit 7 set are negated to magnitude.
    always_comb begin
        w_legal    = (i_op <= 3'd5);
        w_signed_a = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd5);
        w_signed_b = (i_op == 3'd1) || (i_op == 3'd4);
        w_neg_a    = i_rd[7] & w_signed_a;
        w_neg_b    = i_rr[7] & w_signed_b;
        w_ma       = w_neg_a ? (~i_rd + 8'd1) : i_rd;
        w_mb       = w_neg_b ? (~i_rr + 8'd1) : i_rr;
        w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
        w_accept   = i_start & ~i_kill & w_legal & w_idle_like;
        w_zero_op  = SKIP_EN & ((w_ma == 8'h00) | (w_mb == 8'h00));
    end

    always_comb begin
        w_addend = {8'h00, r_ma} << r_cnt;
        w_acc_nx = r_mb[r_cnt] ? (r_acc + w_addend) : r_acc;
        w_p      = r_neg ? (~r_acc + 16'd1) : r_acc;
        w_r_fix  = r_frac ? {w_p[14:0], 1'b0} : w_p;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nx = w_zero_op ? S_FIX : S_CALC;
            end
            S_CALC: begin
                if (i_kill)             w_state_nx = S_IDLE;
                else if (r_cnt == 3'd7) w_state_nx = S_FIX;
            end
            S_FIX: begin
                w_state_nx = i_kill ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (w_accept) w_state_nx = w_zero_op ? S_FIX : S_CALC;
                else          w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_ma     <= 8'h00;
            r_mb     <= 8'h00;
            r_neg    <= 1'b0;
            r_frac   <= 1'b0;
            r_acc    <= 16'h0000;
            r_r      <= 16'h0000;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_ma   <= w_ma;
                r_mb   <= w_mb;
                r_neg  <= w_neg_a ^ w_neg_b;
                r_frac <= (i_op >= 3'd3);
                r_acc  <= 16'h0000;
                r_cnt  <= 3'd0;
            end else if ((r_state == S_CALC) && !i_kill) begin
                r_acc <= w_acc_nx;
                r_cnt <= r_cnt + 3'd1;
            end
            // Results only move at a surviving FIX edge; they persist across later operations.
            if ((r_state == S_FIX) && !i_kill) begin
                r_r      <= w_r_fix;
                r_flag_c <= w_p[15];
                r_flag_z <= (w_r_fix == 16'h0000);
            end
        end
    end

    assign o_busy   = (r_state == S_CALC) || (r_state == S_FIX);
    assign o_done   = (r_state == S_DONE);
    assign o_r      = r_r;
    assign o_flag_c = r_flag_c;
    assign o_flag_z = r_flag_z;

endmodule

// File: doc/mega_mul_seq.md
Name: mega_mul_seq

Overview:
- Iterative shift-add sequencer for the AVR multiply family: MUL, MULS, MULSU, FMUL, FMULS, FMULSU.
- Used in low-resource builds that have no DSP multiplier. The core decoder pulses start with the decoded op and stalls the pipeline while busy.
- On done it writes R into the Rd+1:Rd pair (r1:r0) and merges C/Z into SREG.
- Results and flags are bit-exact to the single-cycle ALU multiply path.

Parameters:
- ZERO_SKIP, "FALSE", when "TRUE" an operand of 0x00 bypasses CALC: IDLE -> FIX directly, so done arrives 8 cycles earlier.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE or DONE
- op  input  3  0 MUL, 1 MULS, 2 MULSU, 3 FMUL, 4 FMULS, 5 FMULSU; 6/7 illegal
- rd  input  8  multiplicand (Rd)
- rr  input  8  multiplier (Rr)
- kill  input  1  synchronous abort (pipeline flush or interrupt)
- busy  output  1  operation in progress; core stalls while high
- done  output  1  one-cycle result-valid strobe
- R  output  16  product
- flag_c  output  1  SREG C
- flag_z  output  1  SREG Z

Behaviour:
- Reset (rst=1 at a clock edge, regardless of state): state=IDLE, busy=0, done=0, R=0, flag_c=0, flag_z=0, counter=0. Reset mid-operation discards the operation and done is never asserted for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start + legal op, at the edge:
  - Latch the signedness of op.
  - Latch magnitudes: ma = rd[7] & signed_a ? -rd : rd; mb = rr[7] & signed_b ? -rr : rr. Both are 8-bit unsigned; 0x80 gives 128.
  - signed_a is set for ops 1, 2, 4, 5. signed_b is set for ops 1 and 4 only.
  - neg = (rd[7]&signed_a) ^ (rr[7]&signed_b). frac = op>=3.
  - acc=0, cnt=0, go to CALC.
- Illegal op (6/7) with start: ignored, state unchanged, no done.
- CALC: one multiplier bit per cycle, LSB first: if mb[cnt], acc += {ma,<<cnt} in 16-bit; cnt++. After 8 cycles (cnt==7 at the edge) go to FIX.
- FIX (1 cycle):
  - p = neg ? -acc : acc (16-bit two's complement).
  - Non-frac ops: R=p, flag_c=p[15].
  - Frac ops: R={p[14:0],1'b0}, flag_c=p[15].
  - flag_z = (new R == 16'h0000).
  - Go to DONE.
- DONE (1 cycle): done=1. Go to IDLE, or to CALC if a legal start arrives this same cycle (back-to-back).
- Latency: start at cycle t gives busy=1 in cycles t+1..t+9 and done=1 in cycle t+10 with busy=0. With ZERO_SKIP="TRUE" and ma==0 or mb==0, done is in cycle t+2.
- start while busy is ignored; inputs are not re-sampled.
- R, flag_c and flag_z update only at the FIX edge. They hold their value through IDLE and the next operation's CALC until the next FIX.
- kill at an edge in CALC or FIX: go to IDLE, busy=0, no done, R and flags unchanged.
- kill in IDLE/DONE: start in the same cycle is suppressed; done already asserted in DONE is unaffected.
- kill and start in the same cycle: kill wins.
- rd/rr may change after the start cycle without effect.

Test Plan:
- MUL rd=0xFF rr=0xFF -> done at t+10, R=0xFE01, C=1, Z=0; busy high exactly 9 cycles.
- MULS 0x80*0x80 -> R=0x4000, C=0. MULS 0xFF*0x01 -> R=0xFFFF, C=1.
- MULSU rd=0xFF (-1), rr=0xFF (255) -> R=0xFF01, C=1. MULSU 0x80*0xFF -> R=0x8080, C=1.
- Fractional ops:
  - FMUL 0x80*0x80 -> R=0x8000, C=0.
  - FMULS 0x80*0x80 -> R=0x8000, C=0.
  - FMUL 0xFF*0xFF -> R=0xFC02, C=1.
  - FMULSU 0x00*0x55 -> R=0x0000, Z=1; with ZERO_SKIP="TRUE" the same case gives done at t+2.
- Back-to-back and kill:
  - start in a DONE cycle -> second done exactly 10 cycles later.
  - start while busy -> ignored.
  - kill in the 4th CALC cycle -> IDLE next cycle, no done, R keeps the previous 0xFE01.
- Reset and illegal op:
  - rst in CALC -> all outputs 0 next cycle, no done.
  - op=6 with start -> no busy, no done.
